// File: rtl/cla_seq_add_ctrl_pkg.sv
// Shared types and helpers for the sequential carry-lookahead adder controller.
// Optional subtract support is enabled by defining CLA_SEQ_SUB_EN.
package cla_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  localparam int DEF_NUMBITS   = 32;
  localparam int DEF_SLICEBITS = 8;

  function automatic int calc_nslices(input int numbits, input int slicebits);
    return numbits / slicebits;
  endfunction

  // The slice adder is built from 4-bit lookahead groups, and the operand is
  // consumed a whole slice at a time.
  function automatic bit cfg_ok(input int numbits, input int slicebits);
    return (slicebits > 0) && (numbits % slicebits == 0) && (slicebits % 4 == 0);
  endfunction

endpackage

// File: rtl/cla_seq_add_ctrl_if.sv
// Request/response bundle for cla_seq_add_ctrl; sub_in exists only with CLA_SEQ_SUB_EN.
interface cla_seq_add_ctrl_if
  import cla_seq_pkg::*;
#(
  parameter int NUMBITS = DEF_NUMBITS
);
  logic               req_valid;
  logic               req_ready;
  logic [NUMBITS-1:0] a_in;
  logic [NUMBITS-1:0] b_in;
  logic               c_in;
`ifdef CLA_SEQ_SUB_EN
  logic               sub_in;
`endif
  logic               rsp_valid;
  logic               rsp_ready;
  logic [NUMBITS-1:0] s_out;
  logic               c_out;
  logic               busy;

  modport master (
    output req_valid, a_in, b_in, c_in,
`ifdef CLA_SEQ_SUB_EN
    output sub_in,
`endif
    output rsp_ready,
    input  req_ready, rsp_valid, s_out, c_out, busy
  );

  modport slave (
    input  req_valid, a_in, b_in, c_in,
`ifdef CLA_SEQ_SUB_EN
    input  sub_in,
`endif
    input  rsp_ready,
    output req_ready, rsp_valid, s_out, c_out, busy
  );
endinterface

// File: rtl/cla_seq_add_ctrl_cla.sv
// Combinational carry-lookahead adder: 4-bit lookahead groups chained by group carry.
module nBitCarryLookAheadAdder #(
  parameter int NUMBITS = 8
) (
  input  logic [NUMBITS-1:0] a,
  input  logic [NUMBITS-1:0] b,
  input  logic               c_in,
  output logic [NUMBITS-1:0] s,
  output logic               c_out
);
  localparam int NGRP = NUMBITS / 4;

  logic [NGRP:0] grp_c;

  assign grp_c[0] = c_in;

  genvar gi;
  generate
    for (gi = 0; gi < NGRP; gi++) begin : g_grp
      logic [3:0] p;
      logic [3:0] g;
      logic [4:0] c;

      assign p    = a[4*gi +: 4] ^ b[4*gi +: 4];
      assign g    = a[4*gi +: 4] & b[4*gi +: 4];
      assign c[0] = grp_c[gi];
      assign c[1] = g[0] | (p[0] & c[0]);
      assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                  | (p[2] & p[1] & p[0] & c[0]);
      assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);

      assign s[4*gi +: 4] = p ^ c[3:0];
      assign grp_c[gi+1]  = c[4];
    end
  endgenerate

  assign c_out = grp_c[NGRP];
endmodule

// File: rtl/cla_seq_add_ctrl.sv
// Wide add sequenced over one narrow CLA slice, LSB slice first.
// Define CLA_SEQ_SUB_EN to add a subtract request (sub_in) computing a-b.
module cla_seq_add_ctrl
  import cla_seq_pkg::*;
#(
  parameter int NUMBITS   = DEF_NUMBITS,
  parameter int SLICEBITS = DEF_SLICEBITS
) (
  input logic               clk,
  input logic               reset,
  cla_seq_add_ctrl_if.slave bus
);
  localparam int NSLICES = calc_nslices(NUMBITS, SLICEBITS);
  localparam int IDXW    = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICES - 1);

  generate
    if (!cfg_ok(NUMBITS, SLICEBITS)) begin : g_cfg_err
      $error("cla_seq_add_ctrl: NUMBITS must be a multiple of SLICEBITS, SLICEBITS a multiple of 4");
    end
  endgenerate

  seq_state_t         state_reg;
  logic [NUMBITS-1:0] a_sh_reg;
  logic [NUMBITS-1:0] b_sh_reg;
  logic [NUMBITS-1:0] res_reg;
  logic               carry_reg;
  logic [IDXW-1:0]    idx_reg;
  logic               req_ready_reg;
  logic               rsp_valid_reg;
  logic               busy_reg;
  logic [NUMBITS-1:0] s_out_reg;
  logic               c_out_reg;

  logic [SLICEBITS-1:0]         slice_s;
  logic                         slice_c;
  logic [NUMBITS+SLICEBITS-1:0] res_cat;
  logic [NUMBITS-1:0]           res_next;
  logic [NUMBITS-1:0]           b_load;
  logic                         c_load;

  // Subtraction is a + ~b + 1, so only the captured B and carry change.
`ifdef CLA_SEQ_SUB_EN
  assign b_load = bus.b_in ^ {NUMBITS{bus.sub_in}};
  assign c_load = bus.sub_in | bus.c_in;
`else
  assign b_load = bus.b_in;
  assign c_load = bus.c_in;
`endif

  nBitCarryLookAheadAdder #(
    .NUMBITS (SLICEBITS)
  ) u_slice (
    .a     (a_sh_reg[SLICEBITS-1:0]),
    .b     (b_sh_reg[SLICEBITS-1:0]),
    .c_in  (carry_reg),
    .s     (slice_s),
    .c_out (slice_c)
  );

  // New slice enters at the MSB end; after NSLICES shifts slice 0 sits at the LSB.
  assign res_cat  = {slice_s, res_reg};
  assign res_next = res_cat[NUMBITS+SLICEBITS-1:SLICEBITS];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      a_sh_reg      <= '0;
      b_sh_reg      <= '0;
      res_reg       <= '0;
      carry_reg     <= 1'b0;
      idx_reg       <= '0;
      req_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      s_out_reg     <= '0;
      c_out_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.req_valid && req_ready_reg) begin
            a_sh_reg      <= bus.a_in;
            b_sh_reg      <= b_load;
            carry_reg     <= c_load;
            idx_reg       <= '0;
            req_ready_reg <= 1'b0;
            busy_reg      <= 1'b1;
            state_reg     <= RUN;
          end
        end
        RUN: begin
          a_sh_reg  <= a_sh_reg >> SLICEBITS;
          b_sh_reg  <= b_sh_reg >> SLICEBITS;
          res_reg   <= res_next;
          carry_reg <= slice_c;
          idx_reg   <= idx_reg + IDXW'(1);
          if (idx_reg == LAST_IDX) begin
            s_out_reg     <= res_next;
            c_out_reg     <= slice_c;
            rsp_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          // Response only; a request seen this cycle waits for IDLE.
          if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            req_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.busy      = busy_reg;
  assign bus.s_out     = s_out_reg;
  assign bus.c_out     = c_out_reg;
endmodule

// File: tb/tb_cla_seq_add_ctrl.sv
// Directed bench for cla_seq_add_ctrl with an expected-result queue.
// Subtract steps run only when CLA_SEQ_SUB_EN is defined.
module tb_cla_seq_add_ctrl;
  localparam int NB = 32;
  localparam int SB = 8;
  localparam int NS = NB / SB;

  typedef struct packed {
    logic [NB-1:0] s;
    logic          c;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  cla_seq_add_ctrl_if #(.NUMBITS(NB)) bus ();

  cla_seq_add_ctrl #(
    .NUMBITS   (NB),
    .SLICEBITS (SB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [NB-1:0] a, input logic [NB-1:0] b,
                                 input logic c, input logic sub);
    logic [NB:0] full;
    exp_t e;
    if (sub) full = {1'b0, a} + {1'b0, ~b} + {{NB{1'b0}}, 1'b1};
    else     full = {1'b0, a} + {1'b0, b} + {{NB{1'b0}}, c};
    e.s = full[NB-1:0];
    e.c = full[NB];
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ops(input logic [NB-1:0] a, input logic [NB-1:0] b,
                           input logic c, input logic sub);
    bus.a_in = a;
    bus.b_in = b;
    bus.c_in = c;
`ifdef CLA_SEQ_SUB_EN
    bus.sub_in = sub;
`endif
  endtask

  task automatic issue(input logic [NB-1:0] a, input logic [NB-1:0] b,
                       input logic c, input logic sub);
    int n = 0;
    while (!bus.req_ready && n < 20) begin
      cyc();
      n++;
    end
    chk("req_ready_before_issue", bus.req_ready, 1);
    drive_ops(a, b, c, sub);
    bus.req_valid = 1'b1;
    cyc();
    sb_q.push_back(model(a, b, c, sub));
    bus.req_valid = 1'b0;
    chk("busy_after_accept", bus.busy, 1);
    chk("req_ready_after_accept", bus.req_ready, 0);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!bus.rsp_valid && lat < 20) begin
      cyc();
      lat++;
    end
    chk("rsp_valid_timeout", bus.rsp_valid, 1);
  endtask

  task automatic take_rsp(input string tag);
    exp_t e;
    logic [NB-1:0] held;
    chk({tag, "_queue_nonempty"}, (sb_q.size() > 0), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_s_out"}, bus.s_out, e.s);
      chk({tag, "_c_out"}, bus.c_out, e.c);
      $display("[TB] %s: s_out=0x%08h c_out=%0d exp s=0x%08h c=%0d", tag, bus.s_out, bus.c_out, e.s, e.c);
    end
    held = bus.s_out;
    bus.rsp_ready = 1'b1;
    cyc();
    bus.rsp_ready = 1'b0;
    chk({tag, "_rsp_valid_clear"}, bus.rsp_valid, 0);
    chk({tag, "_req_ready_back"}, bus.req_ready, 1);
    chk({tag, "_busy_clear"}, bus.busy, 0);
    chk({tag, "_s_out_held_idle"}, bus.s_out, held);
  endtask

  initial begin
    int lat;
    logic [NB-1:0] bp_s;
    logic bp_c;
    logic [NB-1:0] ra, rb;
    logic rc;

    // Reset with random inputs
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.req_valid = 1'($urandom);
      bus.rsp_ready = 1'($urandom);
      drive_ops($urandom, $urandom, 1'($urandom), 1'b0);
      cyc();
    end
    chk("reset_req_ready", bus.req_ready, 1);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_s_out", bus.s_out, 0);
    chk("reset_c_out", bus.c_out, 0);
    reset = 1'b0;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    cyc();

    // Full carry ripple
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    wait_rsp(lat);
    chk("ripple_latency", lat, NS);
    chk("ripple_s_const", bus.s_out, 32'h0000_0000);
    chk("ripple_c_const", bus.c_out, 1);
    take_rsp("ripple");

    // Mixed operands with carry-in
    issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0);
    wait_rsp(lat);
    chk("mixed_latency", lat, NS);
    chk("mixed_s_const", bus.s_out, 32'hACF1_3569);
    take_rsp("mixed");

    // Backpressure with a competing request held on the bus
    issue(32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 1'b0);
    wait_rsp(lat);
    bp_s = bus.s_out;
    bp_c = bus.c_out;
    drive_ops(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, 1'b0);
    bus.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_rsp_valid", bus.rsp_valid, 1);
      chk("bp_req_ready", bus.req_ready, 0);
      chk("bp_s_stable", bus.s_out, bp_s);
      chk("bp_c_stable", bus.c_out, bp_c);
    end
    take_rsp("bp_first");
    cyc();
    sb_q.push_back(model(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, 1'b0));
    bus.req_valid = 1'b0;
    chk("bp_second_accepted", bus.busy, 1);
    wait_rsp(lat);
    chk("bp_second_latency", lat, NS);
    take_rsp("bp_second");

    // Reset in the middle of RUN
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    sb_q.delete();
    chk("midrst_req_ready", bus.req_ready, 1);
    chk("midrst_rsp_valid", bus.rsp_valid, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_s_out", bus.s_out, 0);
    chk("midrst_c_out", bus.c_out, 0);
    issue(32'd3, 32'd4, 1'b0, 1'b0);
    wait_rsp(lat);
    chk("after_rst_s_const", bus.s_out, 32'd7);
    take_rsp("after_rst");

    // A few random additions
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom);
      issue(ra, rb, rc, 1'b0);
      wait_rsp(lat);
      chk("rand_latency", lat, NS);
      take_rsp("rand");
    end

`ifdef CLA_SEQ_SUB_EN
    issue(32'd5, 32'd7, 1'b1, 1'b1);
    wait_rsp(lat);
    chk("sub_neg_s_const", bus.s_out, 32'hFFFF_FFFE);
    chk("sub_neg_c_const", bus.c_out, 0);
    take_rsp("sub_neg");
    issue(32'd7, 32'd5, 1'b0, 1'b1);
    wait_rsp(lat);
    chk("sub_pos_s_const", bus.s_out, 32'd2);
    chk("sub_pos_c_const", bus.c_out, 1);
    take_rsp("sub_pos");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cla_seq_add_ctrl.md
Name: cla_seq_add_ctrl

Overview:
- Sequencer that performs a wide NUMBITS add by time-multiplexing one narrow SLICEBITS carry-lookahead adder over NUMBITS/SLICEBITS cycles.
- Uses a valid/ready request/response handshake.
- The slice adder is an instance of nBitCarryLookAheadAdder with NUMBITS=SLICEBITS.
- Sits between operand-issuing logic and consumers where area matters more than single-cycle add latency.

Parameters:
- NUMBITS, 32, operand and result width; must be a multiple of SLICEBITS.
- SLICEBITS, 8, width of the per-cycle adder slice; must be a multiple of 4.
- NSLICES (localparam), NUMBITS/SLICEBITS, cycles per add.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request operands valid.
- req_ready  output  1  controller can accept a request.
- a_in  input  NUMBITS  operand A.
- b_in  input  NUMBITS  operand B.
- c_in  input  1  carry-in.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts result.
- s_out  output  NUMBITS  registered sum.
- c_out  output  1  registered carry-out.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, busy=0, s_out=0, c_out=0, slice index=0, carry reg=0.
- State IDLE:
  - req_ready=1.
  - On req_valid&req_ready, capture a_in, b_in into shift registers and c_in into the carry reg.
  - Clear the slice index and go to RUN.
- State RUN:
  - req_ready=0.
  - Each cycle, the slice adder takes the low SLICEBITS of the A/B shift registers plus the carry reg.
  - The slice sum is shifted into the MSB end of the result register; A/B shift right by SLICEBITS; carry reg takes slice c_out; index increments.
  - When index==NSLICES-1 is processed, go to DONE.
- State DONE:
  - rsp_valid=1.
  - s_out and c_out are the final result register and carry reg, held stable.
  - On rsp_ready, go to IDLE.
- Latency: request accepted at edge T; rsp_valid is high starting after edge T+NSLICES (4 cycles at default).
- No accept in DONE: req_ready=0 in DONE, so req_valid is ignored. A new request can be accepted no earlier than the cycle after the response handshake.
- Simultaneous rsp_ready and req_valid in DONE: only the response completes.
- Arithmetic: s_out = (a+b+c_in) mod 2^NUMBITS; c_out = bit NUMBITS of the full sum.
- Slice carry chain: slice i carry-in = slice i-1 carry-out.
- s_out/c_out hold their last value through IDLE until overwritten at the end of the next operation.
- Reset mid-RUN or mid-DONE: abort immediately to reset values; partial results are discarded.
- Inputs a_in/b_in/c_in are don't-care except on the accept cycle.

Optional Feature:
- Macro: CLA_SEQ_SUB_EN.
- With the macro: adds input sub_in (1 bit), sampled on the accept cycle.
  - sub_in=1: B is captured inverted and the carry reg is loaded with 1 (c_in ignored), giving s_out=a-b mod 2^NUMBITS.
  - c_out=1 means no borrow.
  - sub_in=0: behaviour identical to the base block.
- Without the macro: no sub_in port; add only.

Decomposition:
- Shared package cla_seq_pkg holds:
  - the state enum (IDLE, RUN, DONE), 2 bits;
  - the default width constants;
  - a function computing NSLICES plus an elaboration check that NUMBITS%SLICEBITS==0 and SLICEBITS%4==0.
- One sub-module: the nBitCarryLookAheadAdder slice instance.
- Control FSM and shift registers stay in cla_seq_add_ctrl.

Test Plan:
- Reset: assert reset 2 cycles with random inputs -> req_ready=1, rsp_valid=0, busy=0, s_out=0, c_out=0.
- Full carry ripple: a=0xFFFFFFFF, b=0x00000001, c_in=0 -> s_out=0x00000000, c_out=1; rsp_valid rises exactly 4 cycles after accept.
- Mixed operands: a=0x12345678, b=0x9ABCDEF0, c_in=1 -> s_out=0xACF13569, c_out=0.
- Backpressure: hold rsp_ready=0 for 5 cycles while driving req_valid=1 with new operands -> s_out/c_out/rsp_valid stable, req_ready=0, no second accept. Release -> IDLE next cycle, then the new request is accepted.
- Reset mid-operation: accept a=0xFFFFFFFF, b=1, pulse reset after 2 RUN cycles -> reset values. Then a=3, b=4, c_in=0 -> s_out=7, c_out=0.
- With CLA_SEQ_SUB_EN: a=5, b=7, sub_in=1 -> s_out=0xFFFFFFFE, c_out=0. Then a=7, b=5, sub_in=1 -> s_out=2, c_out=1.
